// File: rtl/act_lut_loader.sv
// Activation LUT loader: streams N_ENTRIES signed bytes into a LUT, then
// verifies a trailing 8-bit checksum and an optional non-decreasing order.
module act_lut_loader #(
  parameter int N_ENTRIES  = 16,
  parameter int MONO_CHECK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       lut_we,
  output logic [3:0] lut_addr,
  output logic [7:0] lut_wdata,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] sum_q;
  logic [7:0] prev_q;
  logic [7:0] csum_q;
  logic       mono_fail_q;
  logic       lut_we_q;
  logic [3:0] lut_addr_q;
  logic [7:0] lut_wdata_q;
  logic       busy_q;
  logic       done_q;
  logic       error_q;

  logic       accept;
  logic [7:0] sum_d;
  logic       mono_viol;
  logic       last_entry;
  logic       csum_ok;

  // Abort masks ready combinationally so a byte offered on the abort edge is never taken.
  assign in_ready   = busy_q & ~abort;
  assign accept     = in_valid & in_ready;
  assign sum_d      = sum_q + in_data;
  assign mono_viol  = (MONO_CHECK != 0) && (cnt_q != 4'd0) &&
                      ($signed(in_data) < $signed(prev_q));
  assign last_entry = (cnt_q == 4'(N_ENTRIES - 1));
  assign csum_ok    = (csum_q == sum_q) && !mono_fail_q;

  assign lut_we    = lut_we_q;
  assign lut_addr  = lut_addr_q;
  assign lut_wdata = lut_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  // Load sequencer with registered LUT write port and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sum_q       <= 8'd0;
      prev_q      <= 8'd0;
      csum_q      <= 8'd0;
      mono_fail_q <= 1'b0;
      lut_we_q    <= 1'b0;
      lut_addr_q  <= 4'd0;
      lut_wdata_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      lut_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= LOAD;
            busy_q      <= 1'b1;
            cnt_q       <= 4'd0;
            sum_q       <= 8'd0;
            prev_q      <= 8'd0;
            mono_fail_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end else if (accept) begin
            lut_we_q    <= 1'b1;
            lut_addr_q  <= cnt_q;
            lut_wdata_q <= in_data;
            sum_q       <= sum_d;
            prev_q      <= in_data;
            if (mono_viol) begin
              mono_fail_q <= 1'b1;
            end
            // Counter parks on the last index so it can never address past the table.
            if (last_entry) begin
              state_q <= CHECK;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        CHECK: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end else if (accept) begin
            csum_q  <= in_data;
            state_q <= FINISH;
            busy_q  <= 1'b0;
          end
        end
        FINISH: begin
          done_q  <= csum_ok;
          error_q <= ~csum_ok;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_lut_loader.sv
// Scoreboard bench for act_lut_loader: expected LUT writes are queued at each
// accepted entry and matched against the write port one cycle later.
module tb_act_lut_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic       in_ready, lut_we, busy, done, error;
  logic [3:0] lut_addr;
  logic [7:0] lut_wdata;
  logic       in_ready_m0, lut_we_m0, busy_m0, done_m0, error_m0;
  logic [3:0] lut_addr_m0;
  logic [7:0] lut_wdata_m0;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    time        t;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ent [16];
  int         errors = 0;
  int         checks = 0;
  int         wc = 0;
  int         wc0 = 0;

  always #5 clk = ~clk;

  act_lut_loader #(.N_ENTRIES(16), .MONO_CHECK(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .busy(busy), .done(done), .error(error)
  );

  act_lut_loader #(.N_ENTRIES(16), .MONO_CHECK(0)) dut_m0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_m0), .in_data(in_data),
    .lut_we(lut_we_m0), .lut_addr(lut_addr_m0), .lut_wdata(lut_wdata_m0),
    .busy(busy_m0), .done(done_m0), .error(error_m0)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Write-port monitor for the main instance, compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && lut_we) begin
      wc++;
      if (sb_q.size() == 0) begin
        check_val("spurious_we", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("we_addr", int'(lut_addr), int'(e.a));
        check_val("we_data", int'(lut_wdata), int'(e.d));
        check_val("we_latency", int'($time - e.t), 5);
      end
    end
  end

  // Write counter for the instance without the monotonic check.
  always @(negedge clk) begin
    if (!rst && lut_we_m0) wc0++;
  end

  task automatic send(input logic [7:0] d, input bit push, input logic [3:0] a, input bit rnd);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = d;
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc && push) sb_q.push_back('{a: a, d: d, t: $time});
      n++;
    end
    if (!acc) check_val("accept_timeout", 0, 1);
  endtask

  task automatic pulse_start(input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_val("start_busy", int'(busy), 1);
    check_val("start_done_clr", int'(done), 0);
    check_val("start_err_clr", int'(error), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_val("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic run_load(input bit rnd, input logic [7:0] cs, input bit with_abort);
    int w0 = wc;
    pulse_start(with_abort);
    for (int i = 0; i < 16; i++) begin
      send(ent[i], 1'b1, 4'(i), rnd);
      if (rnd && i == 8) begin
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    send(cs, 1'b0, 4'd0, rnd);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    check_val("write_count", wc - w0, 16);
    check_val("sb_empty", sb_q.size(), 0);
  endtask

  function automatic logic [7:0] model_sum();
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 16; i++) s = s + ent[i];
    return s;
  endfunction

  initial begin
    int w0;
    #3;
    check_val("rst_in_ready", int'(in_ready), 0);
    check_val("rst_lut_we", int'(lut_we), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_error", int'(error), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) ent[i] = 8'(-128 + 16 * i);
    check_val("model_sum_ramp", int'(model_sum()), 128);
    run_load(1'b0, 8'h80, 1'b0);
    check_val("ok_done", int'(done), 1);
    check_val("ok_error", int'(error), 0);

    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("idle_abort_done", int'(done), 1);
    check_val("idle_abort_busy", int'(busy), 0);

    run_load(1'b0, 8'h00, 1'b0);
    check_val("badcs_done", int'(done), 0);
    check_val("badcs_error", int'(error), 1);

    for (int i = 0; i < 16; i++) ent[i] = 8'(i);
    ent[7] = 8'hFF;
    w0 = wc0;
    run_load(1'b0, model_sum(), 1'b0);
    check_val("mono_error", int'(error), 1);
    check_val("mono_done", int'(done), 0);
    check_val("nomono_done", int'(done_m0), 1);
    check_val("nomono_error", int'(error_m0), 0);
    check_val("nomono_writes", wc0 - w0, 16);

    for (int i = 0; i < 16; i++) ent[i] = 8'(-128 + 16 * i);
    run_load(1'b1, 8'h80, 1'b0);
    check_val("rnd_done", int'(done), 1);
    check_val("rnd_error", int'(error), 0);

    w0 = wc;
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) send(ent[i], 1'b1, 4'(i), 1'b0);
    @(negedge clk);
    in_data = 8'h7F;
    abort = 1'b1;
    #1;
    check_val("abort_ready", int'(in_ready), 0);
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_error", int'(error), 0);
    repeat (3) @(negedge clk);
    check_val("abort_writes", wc - w0, 5);
    check_val("abort_sb_empty", sb_q.size(), 0);
    run_load(1'b0, 8'h80, 1'b0);
    check_val("reload_done", int'(done), 1);

    w0 = wc;
    for (int i = 0; i < 16; i++) ent[i] = 8'(i);
    pulse_start(1'b0);
    for (int i = 0; i < 9; i++) send(ent[i], 1'b1, 4'(i), 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ent[9];
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_in_ready", int'(in_ready), 0);
    check_val("arst_lut_we", int'(lut_we), 0);
    check_val("arst_addr", int'(lut_addr), 0);
    check_val("arst_wdata", int'(lut_wdata), 0);
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_done", int'(done), 0);
    check_val("arst_error", int'(error), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("post_rst_busy", int'(busy), 0);
    check_val("post_rst_writes", wc - w0, 9);
    check_val("post_rst_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/act_lut_loader.md
ACT_LUT_LOADER -- requirements
Module: act_lut_loader

Interface
REQ-001 Parameter: N_ENTRIES, default 16, number of activation LUT entries written per load (address width 4).
REQ-002 Parameter: MONO_CHECK, default 1, nonzero enables non-decreasing check on loaded entries.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  pulse, begins a load when idle.
REQ-006 Port: abort  input  1  synchronous cancel of a load in progress.
REQ-007 Port: in_valid  input  1  upstream byte valid.
REQ-008 Port: in_ready  output  1  loader can accept a byte.
REQ-009 Port: in_data  input  8  signed table entry or checksum byte.
REQ-010 Port: lut_we  output  1  LUT write strobe.
REQ-011 Port: lut_addr  output  4  LUT write address.
REQ-012 Port: lut_wdata  output  8  signed LUT write data.
REQ-013 Port: busy  output  1  load in progress.
REQ-014 Port: done  output  1  sticky, last load completed and valid.
REQ-015 Port: error  output  1  sticky, last load failed checksum or monotonic check.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, CHECK, FINISH; busy=1 in LOAD and CHECK only.
REQ-017 Byte transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready=1 only in LOAD and CHECK.
REQ-018 IDLE: start=1 -> LOAD next cycle; entry counter, running sum, previous-entry register cleared; done and error cleared.
REQ-019 start while busy SHALL be ignored.
REQ-020 LOAD: byte accepted at edge k -> lut_we=1, lut_addr=counter, lut_wdata=byte during cycle k+1 (exactly one cycle); counter increments by 1.
REQ-021 Running sum SHALL be 8-bit two's-complement sum of accepted entries, wrapping modulo 256.
REQ-022 MONO_CHECK nonzero: entry at index>0 signed-less-than previous entry SHALL set a mono-fail flag; write still performed, load continues.
REQ-023 Acceptance of entry N_ENTRIES-1 -> CHECK next cycle; counter never exceeds N_ENTRIES-1 as lut_addr.
REQ-024 CHECK: next accepted byte is checksum; no LUT write; -> FINISH next cycle.
REQ-025 FINISH (one cycle): done=1 if checksum equals running sum and no mono-fail, else error=1; -> IDLE.
REQ-026 done and error SHALL be mutually exclusive and hold until next accepted start or reset.
REQ-027 in_valid=0 stalls in LOAD/CHECK indefinitely, no timeout.
REQ-028 abort=1 in LOAD or CHECK -> IDLE next cycle, done=0, error=0, no further lut_we; byte presented same edge not accepted (in_ready forced 0 while abort=1); abort in IDLE/FINISH ignored.
REQ-029 abort and start same cycle in IDLE: start wins.
REQ-030 LUT contents already written before abort are not restored; consumers SHALL gate on done.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, counter=0, sum=0, and outputs in_ready=0, lut_we=0, lut_addr=0, lut_wdata=0, busy=0, done=0, error=0.
REQ-032 Reset mid-load SHALL drop any pending write strobe; no write occurs after rst deasserts until new start.

Verification
REQ-033 start; stream 16 entries -128,-112,...,112 (step 16) back-to-back; checksum -128 (0x80) -> 16 writes addr 0..15 one cycle after each accept, done=1, error=0.
REQ-034 Same entries, checksum 0x00 -> error=1, done=0, all 16 writes still performed.
REQ-035 Entries 0..15 with entry 7 = -1, correct checksum, MONO_CHECK=1 -> error=1; same with MONO_CHECK=0 -> done=1.
REQ-036 in_valid toggled randomly (50%) during load -> write sequence and final done identical to REQ-033.
REQ-037 abort after 5 entries, then start and full valid load -> exactly 5 then 16 writes, final done=1.
REQ-038 rst asserted asynchronously between edges after entry 9 -> outputs zero at once, lut_we never asserted for entry 9, busy=0 after release.
